// File: rtl/ds_mean_decoder.sv
// ds_mean_decoder
//   Receive-side decoder for the 4-bit MASH 1-1-1 delta-sigma stream.
//   One measurement boxcar-averages 2^LOG2_WIN samples into an exact 4.16
//   mean, then compares it against an expected value captured at start.
//
// Parameters
//   LOG2_WIN   : log2 of the averaging window N (4..16)
//   SETTLE_CYC : samples discarded after start before accumulating (0..255)
//
// Ports
//   clk     in   clock
//   rst_n   in   asynchronous, active-low reset
//   start   in   request a measurement (only looked at while idle)
//   ds_in   in   [3:0]  modulator sample, one per cycle
//   exp_i   in   [3:0]  expected integer part   (captured on accepted start)
//   exp_f   in   [15:0] expected fraction /2^16 (captured on accepted start)
//   tol     in   [15:0] allowed |err| in 2^-16 units (captured on accepted start)
//   busy    out  measurement in progress
//   done    out  one-cycle pulse when the result registers update
//   mean_i  out  [3:0]  recovered integer part
//   mean_f  out  [15:0] recovered fractional part
//   err     out  [20:0] signed mean - expected, two's complement
//   pass    out  |err| <= tol
module ds_mean_decoder #(
    parameter int LOG2_WIN   = 16,
    parameter int SETTLE_CYC = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  ds_in,
    input  logic [3:0]  exp_i,
    input  logic [15:0] exp_f,
    input  logic [15:0] tol,
    output logic        busy,
    output logic        done,
    output logic [3:0]  mean_i,
    output logic [15:0] mean_f,
    output logic [20:0] err,
    output logic        pass
);

    localparam int ACC_W = 4 + LOG2_WIN;
    localparam int SHIFT = 16 - LOG2_WIN;
    // Last settle count; only meaningful when SETTLE_CYC > 0.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_CALC
    } state_t;

    state_t              state_q;
    logic [ACC_W-1:0]    accum_q;
    logic [7:0]          settle_cnt_q;
    logic [LOG2_WIN-1:0] win_cnt_q;
    logic [3:0]          exp_i_q;
    logic [15:0]         exp_f_q;
    logic [15:0]         tol_q;

    logic                busy_q;
    logic                done_q;
    logic [3:0]          mean_i_q;
    logic [15:0]         mean_f_q;
    logic [20:0]         err_q;
    logic                pass_q;

    // Result datapath, evaluated from the finished accumulator in CALC.
    // The sum of N samples scaled by 2^16/N is an exact 4.16 mean because
    // N is a power of two no larger than 2^16.
    logic [19:0] mean_d;
    logic [20:0] err_d;
    logic [20:0] err_mag_d;
    logic        pass_d;

    assign mean_d    = 20'(accum_q) << SHIFT;
    assign err_d     = {1'b0, mean_d} - {1'b0, exp_i_q, exp_f_q};
    // 21 bits hold both signs of a +/-(2^20-1) error, so negation is safe.
    assign err_mag_d = err_d[20] ? (21'd0 - err_d) : err_d;
    assign pass_d    = (err_mag_d <= {5'b0, tol_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            accum_q      <= '0;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            exp_i_q      <= '0;
            exp_f_q      <= '0;
            tol_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mean_i_q     <= '0;
            mean_f_q     <= '0;
            err_q        <= '0;
            pass_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        exp_i_q      <= exp_i;
                        exp_f_q      <= exp_f;
                        tol_q        <= tol;
                        accum_q      <= '0;
                        settle_cnt_q <= '0;
                        win_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= (SETTLE_CYC == 0) ? S_ACCUM : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= S_ACCUM;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                S_ACCUM: begin
                    accum_q   <= accum_q + ACC_W'(ds_in);
                    win_cnt_q <= win_cnt_q + 1'b1;
                    // Counter all-ones means this edge adds the N-th sample.
                    if (&win_cnt_q) begin
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    mean_i_q <= mean_d[19:16];
                    mean_f_q <= mean_d[15:0];
                    err_q    <= err_d;
                    pass_q   <= pass_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign mean_i = mean_i_q;
    assign mean_f = mean_f_q;
    assign err    = err_q;
    assign pass   = pass_q;

endmodule

// File: tb/tb_ds_mean_decoder.sv
// Directed bench for ds_mean_decoder. Two instances: LOG2_WIN=8 for the
// directed cases and LOG2_WIN=16 driven by a behavioural MASH 1-1-1 source.
// Expected results go into a queue when the stimulus is driven and are
// popped when the DUT pulses done.
module tb_ds_mean_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic [3:0]  ds_in = 4'd0;
    logic [3:0]  exp_i = 4'd0;
    logic [15:0] exp_f = 16'd0;
    logic [15:0] tol = 16'd0;

    logic        busy8, done8, pass8;
    logic [3:0]  mean_i8;
    logic [15:0] mean_f8;
    logic [20:0] err8;
    logic        busy16, done16, pass16;
    logic [3:0]  mean_i16;
    logic [15:0] mean_f16;
    logic [20:0] err16;

    logic        sel16 = 1'b0;
    logic        busy_s, done_s, pass_s;
    logic [3:0]  mean_i_s;
    logic [15:0] mean_f_s;
    logic [20:0] err_s;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  mi;
        logic [15:0] mf;
        logic [20:0] e;
        logic        p;
    } exp_t;
    exp_t sb[$];

    // MASH 1-1-1 source state
    longint unsigned a1, a2, a3;
    int              c2d, c3d1, c3d2;
    int              mash_ii;
    longint unsigned mash_f;

    always #5 clk = ~clk;

    ds_mean_decoder #(.LOG2_WIN(8), .SETTLE_CYC(10)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ds_in(ds_in),
        .exp_i(exp_i), .exp_f(exp_f), .tol(tol),
        .busy(busy8), .done(done8), .mean_i(mean_i8), .mean_f(mean_f8),
        .err(err8), .pass(pass8)
    );

    ds_mean_decoder #(.LOG2_WIN(16), .SETTLE_CYC(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .ds_in(ds_in),
        .exp_i(exp_i), .exp_f(exp_f), .tol(tol),
        .busy(busy16), .done(done16), .mean_i(mean_i16), .mean_f(mean_f16),
        .err(err16), .pass(pass16)
    );

    always_comb begin
        busy_s   = sel16 ? busy16   : busy8;
        done_s   = sel16 ? done16   : done8;
        mean_i_s = sel16 ? mean_i16 : mean_i8;
        mean_f_s = sel16 ? mean_f16 : mean_f8;
        err_s    = sel16 ? err16    : err8;
        pass_s   = sel16 ? pass16   : pass8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic mash_next(output logic [3:0] y);
        int c1, c2, c3, v;
        a1 = a1 + mash_f;  c1 = int'(a1 >> 16); a1 = a1 & 64'hFFFF;
        a2 = a2 + a1;      c2 = int'(a2 >> 16); a2 = a2 & 64'hFFFF;
        a3 = a3 + a2;      c3 = int'(a3 >> 16); a3 = a3 & 64'hFFFF;
        v = mash_ii + c1 + c2 - c2d + c3 - 2 * c3d1 + c3d2;
        c3d2 = c3d1;
        c3d1 = c3;
        c2d  = c2;
        y = 4'(v);
    endtask

    // mode 0: constant 7; 1: alternating 3/4; 2: 15 during settle then 3; 3: MASH
    // mid_k > 0: pulse start (and scramble the capture inputs) mid-ACCUM.
    task automatic run(input bit big, input int mode, input logic [3:0] ei,
                       input logic [15:0] ef, input logic [15:0] t,
                       input bit use_const, input logic [19:0] mean_c, input int mid_k);
        int          s_cyc;
        int          nwin;
        int          lg;
        longint      sum;
        logic [3:0]  smp;
        logic [19:0] m;
        logic [20:0] e, mag;
        exp_t        ex, got;
        s_cyc = 10;
        nwin  = big ? 65536 : 256;
        lg    = big ? 16 : 8;
        sum   = 0;
        sel16 = big;
        @(negedge clk);
        exp_i = ei; exp_f = ef; tol = t;
        if (big) start16 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        check("busy_after_start", {31'b0, busy_s}, 32'd1);
        for (int k = 1; k <= s_cyc + nwin; k++) begin
            @(negedge clk);
            start8 = 1'b0; start16 = 1'b0;
            if (mid_k > 0 && (k == mid_k || k == mid_k + 37)) begin
                if (big) start16 = 1'b1; else start8 = 1'b1;
                exp_i = ~ei; exp_f = ~ef; tol = 16'd0;
            end
            case (mode)
                0: smp = 4'd7;
                1: smp = (k % 2 == 1) ? 4'd3 : 4'd4;
                2: smp = (k <= 10) ? 4'd15 : 4'd3;
                default: mash_next(smp);
            endcase
            ds_in = smp;
            if (k > s_cyc) sum += longint'(smp);
        end
        m    = use_const ? mean_c : 20'(sum << (16 - lg));
        e    = {1'b0, m} - {1'b0, ei, ef};
        mag  = e[20] ? (21'd0 - e) : e;
        ex.mi = m[19:16];
        ex.mf = m[15:0];
        ex.e  = e;
        ex.p  = (mag <= {5'b0, t});
        sb.push_back(ex);
        @(posedge clk); #1;
        check("done_not_early", {31'b0, done_s}, 32'd0);
        @(posedge clk); #1;
        check("done_pulse", {31'b0, done_s}, 32'd1);
        check("busy_cleared", {31'b0, busy_s}, 32'd0);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("mean_i", {28'b0, mean_i_s}, {28'b0, got.mi});
            check("mean_f", {16'b0, mean_f_s}, {16'b0, got.mf});
            check("err", {11'b0, err_s}, {11'b0, got.e});
            check("pass", {31'b0, pass_s}, {31'b0, got.p});
        end else begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        check("done_single_cycle", {31'b0, done_s}, 32'd0);
    endtask

    initial begin
        int          dn;
        logic [20:0] em;

        a1 = 0; a2 = 0; a3 = 0; c2d = 0; c3d1 = 0; c3d2 = 0;
        mash_ii = 5; mash_f = 12345;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy8}, 32'd0);
        check("rst_done", {31'b0, done8}, 32'd0);
        check("rst_mean", {12'b0, mean_i8, mean_f8}, 32'd0);
        check("rst_err", {11'b0, err8}, 32'd0);
        check("rst_pass", {31'b0, pass8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: constant 7, exp 7.0, tol 0
        run(1'b0, 0, 4'd7, 16'h0000, 16'd0, 1'b1, 20'h70000, 0);
        // 2: alternating 3/4 -> 3.5
        run(1'b0, 1, 4'd3, 16'h8000, 16'd0, 1'b1, 20'h38000, 0);
        // 3: settle samples of 15 are excluded -> 3.0
        run(1'b0, 2, 4'd3, 16'h0000, 16'd0, 1'b1, 20'h30000, 0);
        // 4: err = +16 at the tolerance boundary
        run(1'b0, 0, 4'd6, 16'hFFF0, 16'd16, 1'b1, 20'h70000, 0);
        run(1'b0, 0, 4'd6, 16'hFFF0, 16'd15, 1'b1, 20'h70000, 0);
        // 5a: start pulses mid-ACCUM with scrambled capture inputs
        run(1'b0, 1, 4'd3, 16'h8000, 16'd0, 1'b1, 20'h38000, 30);

        // 5b: reset mid-ACCUM
        sel16 = 1'b0;
        @(negedge clk);
        exp_i = 4'd7; exp_f = 16'h0; tol = 16'd0; start8 = 1'b1; ds_in = 4'd7;
        @(negedge clk);
        start8 = 1'b0;
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy8}, 32'd0);
        check("midrst_done", {31'b0, done8}, 32'd0);
        check("midrst_mean", {12'b0, mean_i8, mean_f8}, 32'd0);
        check("midrst_err", {11'b0, err8}, 32'd0);
        check("midrst_pass", {31'b0, pass8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done8) dn++;
        end
        check("midrst_no_done", dn, 32'd0);

        // 6: LOG2_WIN=16 driven by the MASH source, in 5 + 12345/65536
        run(1'b1, 3, 4'd5, 16'd12345, 16'd4, 1'b0, 20'h0, 0);
        em = err16[20] ? (21'd0 - err16) : err16;
        check("mash_err_bound", {31'b0, (em <= 21'd4)}, 32'd1);
        check("mash_pass", {31'b0, pass16}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
